// File: rtl/memory_access_stage.sv
// Memory access stage: drives a valid/ready data-cache port, steers store lanes, extracts loads,
// and registers write-back results. Optional misalignment trap: `define MEMORY_ACCESS_MISALIGN_TRAP_EN.
module memory_access_stage #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADD_WIDTH    = 5,
    parameter int D_CACHE_LW_WIDTH = 3,
    parameter int D_CACHE_SW_WIDTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
    input  logic [DATA_WIDTH-1:0]       ALU_OUT_IN,
    input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
    input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
    input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA_IN,
    input  logic                        WRITE_BACK_MUX_SELECT_IN,
    input  logic                        RD_WRITE_ENABLE_IN,
    output logic                        DCACHE_REQ,
    output logic                        DCACHE_WRITE,
    output logic [ADDRESS_WIDTH-1:0]    DCACHE_ADDR,
    output logic [3:0]                  DCACHE_WSTRB,
    output logic [DATA_WIDTH-1:0]       DCACHE_WDATA,
    input  logic                        DCACHE_READY,
    input  logic [DATA_WIDTH-1:0]       DCACHE_RDATA,
    output logic                        MEMORY_STALL_REQ,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
    output logic [DATA_WIDTH-1:0]       ALU_OUT,
    output logic [DATA_WIDTH-1:0]       LOAD_DATA_OUT,
    output logic                        WRITE_BACK_MUX_SELECT_OUT,
    output logic                        RD_WRITE_ENABLE_OUT
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic                        MISALIGNED_OUT,
    output logic [ADDRESS_WIDTH-1:0]    MISALIGNED_ADDR_OUT
`endif
);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state_q;

    logic [ADDRESS_WIDTH-1:0] hold_addr_q;
    logic [DATA_WIDTH-1:0]    hold_alu_q;
    logic [DATA_WIDTH-1:0]    hold_wdata_q;
    logic [3:0]               hold_wstrb_q;
    logic                     hold_write_q;
    logic [2:0]               hold_load_q;
    logic [1:0]               hold_off_q;
    logic [REG_ADD_WIDTH-1:0] hold_rd_q;
    logic                     hold_wbsel_q;
    logic                     hold_we_q;

    logic [REG_ADD_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]    alu_q;
    logic [DATA_WIDTH-1:0]    load_q;
    logic                     wbsel_q;
    logic                     we_q;

    logic                     in_store;
    logic [2:0]               in_load;
    logic                     in_mem;
    logic                     misaligned;
    logic                     in_issue;
    logic [ADDRESS_WIDTH-1:0] in_addr;
    logic [3:0]               in_wstrb;
    logic [DATA_WIDTH-1:0]    in_wdata;
    logic                     in_wait;

    logic [2:0]               act_load;
    logic [1:0]               act_off;
    logic                     act_write;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [DATA_WIDTH-1:0]    load_d;
    logic [REG_ADD_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0]    alu_d;
    logic                     wbsel_d;
    logic                     we_d;

    // Decode the incoming op; a store overrides any load code, and 110/111 mean no load.
    always_comb begin
        in_store = (DATA_CACHE_STORE_IN != 2'b00);
        in_load  = (in_store || DATA_CACHE_LOAD_IN > LD_LHU) ? LD_NONE : DATA_CACHE_LOAD_IN;
        in_mem   = in_store || (in_load != LD_NONE);
        in_addr  = {ALU_OUT_IN[ADDRESS_WIDTH-1:2], 2'b00};
        in_wstrb = 4'b0000;
        in_wdata = '0;
        case (DATA_CACHE_STORE_IN)
            ST_SB: begin
                in_wstrb = 4'b0001 << ALU_OUT_IN[1:0];
                in_wdata = {(DATA_WIDTH/8){DATA_CACHE_STORE_DATA_IN[7:0]}};
            end
            ST_SH: begin
                in_wstrb = ALU_OUT_IN[1] ? 4'b1100 : 4'b0011;
                in_wdata = {(DATA_WIDTH/16){DATA_CACHE_STORE_DATA_IN[15:0]}};
            end
            ST_SW: begin
                in_wstrb = 4'b1111;
                in_wdata = DATA_CACHE_STORE_DATA_IN;
            end
            default: ;
        endcase
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        misaligned = ((DATA_CACHE_STORE_IN == ST_SH) && ALU_OUT_IN[0])
                  || ((DATA_CACHE_STORE_IN == ST_SW) && (ALU_OUT_IN[1:0] != 2'b00))
                  || (((in_load == LD_LH) || (in_load == LD_LHU)) && ALU_OUT_IN[0])
                  || ((in_load == LD_LW) && (ALU_OUT_IN[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        in_issue = in_mem && !misaligned;
    end

    assign in_wait   = (state_q == S_WAIT);
    assign act_load  = in_wait ? hold_load_q  : in_load;
    assign act_off   = in_wait ? hold_off_q   : ALU_OUT_IN[1:0];
    assign act_write = in_wait ? hold_write_q : in_store;
    assign rd_d      = in_wait ? hold_rd_q    : RD_ADDRESS_IN;
    assign alu_d     = in_wait ? hold_alu_q   : ALU_OUT_IN;
    assign wbsel_d   = in_wait ? hold_wbsel_q : WRITE_BACK_MUX_SELECT_IN;
    assign we_d      = (in_wait ? hold_we_q : RD_WRITE_ENABLE_IN) && !act_write;

    // Load extraction works from whichever op is in flight, so the same path serves both states.
    always_comb begin
        case (act_off)
            2'd0:    byte_sel = DCACHE_RDATA[7:0];
            2'd1:    byte_sel = DCACHE_RDATA[15:8];
            2'd2:    byte_sel = DCACHE_RDATA[23:16];
            default: byte_sel = DCACHE_RDATA[31:24];
        endcase
        half_sel = act_off[1] ? DCACHE_RDATA[31:16] : DCACHE_RDATA[15:0];
        case (act_load)
            LD_LB:   load_d = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  load_d = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LD_LH:   load_d = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LD_LHU:  load_d = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            LD_LW:   load_d = DCACHE_RDATA;
            default: load_d = '0;
        endcase
    end

    assign DCACHE_REQ       = !RST && (in_wait || in_issue);
    assign DCACHE_WRITE     = act_write;
    assign DCACHE_ADDR      = in_wait ? hold_addr_q  : in_addr;
    assign DCACHE_WSTRB     = in_wait ? hold_wstrb_q : in_wstrb;
    assign DCACHE_WDATA     = in_wait ? hold_wdata_q : in_wdata;
    assign MEMORY_STALL_REQ = DCACHE_REQ && !DCACHE_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            hold_addr_q  <= '0;
            hold_alu_q   <= '0;
            hold_wdata_q <= '0;
            hold_wstrb_q <= '0;
            hold_write_q <= 1'b0;
            hold_load_q  <= '0;
            hold_off_q   <= '0;
            hold_rd_q    <= '0;
            hold_wbsel_q <= 1'b0;
            hold_we_q    <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            load_q       <= '0;
            wbsel_q      <= 1'b0;
            we_q         <= 1'b0;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
            MISALIGNED_OUT      <= 1'b0;
            MISALIGNED_ADDR_OUT <= '0;
`endif
        end else begin
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
            MISALIGNED_OUT <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (in_issue) begin
                        hold_addr_q  <= in_addr;
                        hold_alu_q   <= ALU_OUT_IN;
                        hold_wdata_q <= in_wdata;
                        hold_wstrb_q <= in_wstrb;
                        hold_write_q <= in_store;
                        hold_load_q  <= in_load;
                        hold_off_q   <= ALU_OUT_IN[1:0];
                        hold_rd_q    <= RD_ADDRESS_IN;
                        hold_wbsel_q <= WRITE_BACK_MUX_SELECT_IN;
                        hold_we_q    <= RD_WRITE_ENABLE_IN;
                        if (DCACHE_READY) begin
                            rd_q    <= rd_d;
                            alu_q   <= alu_d;
                            load_q  <= load_d;
                            wbsel_q <= wbsel_d;
                            we_q    <= we_d;
                        end else begin
                            state_q <= S_WAIT;
                            rd_q    <= '0;
                            alu_q   <= '0;
                            load_q  <= '0;
                            wbsel_q <= 1'b0;
                            we_q    <= 1'b0;
                        end
                    end else if (misaligned) begin
                        rd_q    <= '0;
                        alu_q   <= '0;
                        load_q  <= '0;
                        wbsel_q <= 1'b0;
                        we_q    <= 1'b0;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
                        MISALIGNED_OUT      <= 1'b1;
                        MISALIGNED_ADDR_OUT <= ALU_OUT_IN[ADDRESS_WIDTH-1:0];
`endif
                    end else begin
                        rd_q    <= RD_ADDRESS_IN;
                        alu_q   <= ALU_OUT_IN;
                        load_q  <= '0;
                        wbsel_q <= WRITE_BACK_MUX_SELECT_IN;
                        we_q    <= RD_WRITE_ENABLE_IN;
                    end
                end
                default: begin
                    // Inputs are ignored here; only the held op matters until the cache answers.
                    if (DCACHE_READY) begin
                        state_q <= S_IDLE;
                        rd_q    <= rd_d;
                        alu_q   <= alu_d;
                        load_q  <= load_d;
                        wbsel_q <= wbsel_d;
                        we_q    <= we_d;
                    end else begin
                        rd_q    <= '0;
                        alu_q   <= '0;
                        load_q  <= '0;
                        wbsel_q <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign RD_ADDRESS_OUT            = rd_q;
    assign ALU_OUT                   = alu_q;
    assign LOAD_DATA_OUT             = load_q;
    assign WRITE_BACK_MUX_SELECT_OUT = wbsel_q;
    assign RD_WRITE_ENABLE_OUT       = we_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage; follows the DUT's misalignment macro.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_in;
    logic [31:0] alu_in;
    logic [2:0]  ld_in;
    logic [1:0]  st_in;
    logic [31:0] sdata_in;
    logic        wbsel_in;
    logic        we_in;
    logic        req, wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        stall;
    logic [4:0]  rd_out;
    logic [31:0] alu_out;
    logic [31:0] load_out;
    logic        wbsel_out;
    logic        we_out;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    logic        mis_out;
    logic [31:0] mis_addr;
`endif

    int checks = 0;
    int errors = 0;

    memory_access_stage dut (
        .CLK(clk), .RST(rst),
        .RD_ADDRESS_IN(rd_in), .ALU_OUT_IN(alu_in),
        .DATA_CACHE_LOAD_IN(ld_in), .DATA_CACHE_STORE_IN(st_in),
        .DATA_CACHE_STORE_DATA_IN(sdata_in),
        .WRITE_BACK_MUX_SELECT_IN(wbsel_in), .RD_WRITE_ENABLE_IN(we_in),
        .DCACHE_REQ(req), .DCACHE_WRITE(wr), .DCACHE_ADDR(addr),
        .DCACHE_WSTRB(wstrb), .DCACHE_WDATA(wdata),
        .DCACHE_READY(ready), .DCACHE_RDATA(rdata),
        .MEMORY_STALL_REQ(stall),
        .RD_ADDRESS_OUT(rd_out), .ALU_OUT(alu_out), .LOAD_DATA_OUT(load_out),
        .WRITE_BACK_MUX_SELECT_OUT(wbsel_out), .RD_WRITE_ENABLE_OUT(we_out)
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        , .MISALIGNED_OUT(mis_out), .MISALIGNED_ADDR_OUT(mis_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rd, input logic [31:0] a, input logic [2:0] ld,
                         input logic [1:0] st, input logic [31:0] sd, input logic wbs, input logic we);
        rd_in = rd; alu_in = a; ld_in = ld; st_in = st; sdata_in = sd; wbsel_in = wbs; we_in = we;
    endtask

    task automatic bubble();
        drive(5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; rdata = 32'd0;
        drive(5'd9, 32'h40, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1);
        tick(); tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL reset_alu: got %h exp 0", alu_out); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d exp 0", rd_out); end
        checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", we_out); end
        checks++; if (load_out !== 32'd0) begin errors++; $display("FAIL reset_load: got %h exp 0", load_out); end
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        checks++; if (mis_out !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b exp 0", mis_out); end
`endif
        rst = 1'b0;
        bubble();
        tick();
        $display("reset: done");
    endtask

    task automatic test_alu();
        drive(5'd5, 32'h12345678, 3'd0, 2'd0, 32'd0, 1'b0, 1'b1);
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b exp 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b exp 0", stall); end
        tick();
        bubble();
        checks++; if (alu_out !== 32'h12345678) begin errors++; $display("FAIL alu_out: got %h exp 12345678", alu_out); end
        checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d exp 5", rd_out); end
        checks++; if (we_out !== 1'b1) begin errors++; $display("FAIL alu_we: got %b exp 1", we_out); end
        checks++; if (load_out !== 32'd0) begin errors++; $display("FAIL alu_load: got %h exp 0", load_out); end
        $display("alu: rd=%0d alu=%h we=%b", rd_out, alu_out, we_out);
    endtask

    task automatic test_load_extract();
        logic [2:0]  codes [6];
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        codes[0] = 3'd1; addrs[0] = 32'h103; exps[0] = 32'hFFFF_FF80; // LB
        codes[1] = 3'd4; addrs[1] = 32'h103; exps[1] = 32'h0000_0080; // LBU
        codes[2] = 3'd1; addrs[2] = 32'h101; exps[2] = 32'h0000_0012; // LB positive
        codes[3] = 3'd2; addrs[3] = 32'h102; exps[3] = 32'hFFFF_80FF; // LH upper
        codes[4] = 3'd5; addrs[4] = 32'h100; exps[4] = 32'h0000_1234; // LHU lower
        codes[5] = 3'd3; addrs[5] = 32'h100; exps[5] = 32'h80FF_1234; // LW
        ready = 1'b1; rdata = 32'h80FF_1234;
        for (int i = 0; i < 6; i++) begin
            drive(5'd7, addrs[i], codes[i], 2'd0, 32'd0, 1'b1, 1'b1);
            #1;
            checks++; if (req !== 1'b1) begin errors++; $display("FAIL ld%0d_req: got %b exp 1", i, req); end
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL ld%0d_write: got %b exp 0", i, wr); end
            checks++; if (addr !== {addrs[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_addr: got %h exp %h", i, addr, {addrs[i][31:2], 2'b00}); end
            checks++; if (wstrb !== 4'b0000) begin errors++; $display("FAIL ld%0d_wstrb: got %b exp 0000", i, wstrb); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld%0d_stall: got %b exp 0", i, stall); end
            tick();
            checks++; if (load_out !== exps[i]) begin errors++; $display("FAIL ld%0d_data: got %h exp %h", i, load_out, exps[i]); end
            checks++; if (we_out !== 1'b1) begin errors++; $display("FAIL ld%0d_we: got %b exp 1", i, we_out); end
            checks++; if (alu_out !== addrs[i]) begin errors++; $display("FAIL ld%0d_alu: got %h exp %h", i, alu_out, addrs[i]); end
            checks++; if (wbsel_out !== 1'b1) begin errors++; $display("FAIL ld%0d_wbsel: got %b exp 1", i, wbsel_out); end
            $display("load %0d: code=%0d addr=%h data=%h", i, codes[i], addrs[i], load_out);
        end
        bubble();
        tick();
    endtask

    task automatic test_store_wait();
        int req_cycles = 0;
        int stall_cycles = 0;
        ready = 1'b0;
        drive(5'd3, 32'h202, 3'd0, 2'd2, 32'h0000_BEEF, 1'b0, 1'b1);
        #1;
        if (req === 1'b1) req_cycles++;
        if (stall === 1'b1) stall_cycles++;
        checks++; if (wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb0: got %b exp 1100", wstrb); end
        checks++; if (wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata0: got %h exp beefbeef", wdata); end
        checks++; if (addr !== 32'h200) begin errors++; $display("FAIL sh_addr0: got %h exp 200", addr); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            bubble();
            ready = (i == 3);
            checks++; if (we_out !== 1'b0 || alu_out !== 32'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL sh_bubble%0d: got we=%b alu=%h rd=%0d exp all 0", i, we_out, alu_out, rd_out); end
            #1;
            if (req === 1'b1) req_cycles++;
            if (stall === 1'b1) stall_cycles++;
            checks++; if (wr !== 1'b1) begin errors++; $display("FAIL sh_write%0d: got %b exp 1", i, wr); end
            checks++; if (addr !== 32'h200) begin errors++; $display("FAIL sh_addr%0d: got %h exp 200", i, addr); end
            checks++; if (wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb%0d: got %b exp 1100", i, wstrb); end
            checks++; if (wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata%0d: got %h exp beefbeef", i, wdata); end
            checks++; if (stall !== (i != 3)) begin errors++; $display("FAIL sh_stall%0d: got %b exp %b", i, stall, (i != 3)); end
        end
        tick();
        ready = 1'b0;
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL sh_req_cycles: got %0d exp 4", req_cycles); end
        checks++; if (stall_cycles != 3) begin errors++; $display("FAIL sh_stall_cycles: got %0d exp 3", stall_cycles); end
        checks++; if (alu_out !== 32'h202) begin errors++; $display("FAIL sh_done_alu: got %h exp 202", alu_out); end
        checks++; if (rd_out !== 5'd3) begin errors++; $display("FAIL sh_done_rd: got %0d exp 3", rd_out); end
        checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL sh_done_we: got %b exp 0", we_out); end
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL sh_after_req: got %b exp 0", req); end
        $display("store wait: req_cycles=%0d stall_cycles=%0d", req_cycles, stall_cycles);
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        drive(5'd10, 32'h300, 3'd3, 2'd3, 32'hCAFE_BABE, 1'b0, 1'b1);
        #1;
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL sw_write: got %b exp 1", wr); end
        checks++; if (wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b exp 1111", wstrb); end
        checks++; if (wdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL sw_wdata: got %h exp cafebabe", wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b exp 0", stall); end
        tick();
        drive(5'd11, 32'h301, 3'd0, 2'd1, 32'h0000_00A5, 1'b0, 1'b1);
        checks++; if (alu_out !== 32'h300 || rd_out !== 5'd10 || we_out !== 1'b0) begin errors++; $display("FAIL sw_done: got alu=%h rd=%0d we=%b exp 300/10/0", alu_out, rd_out, we_out); end
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL sb_req: got %b exp 1", req); end
        checks++; if (wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb: got %b exp 0010", wstrb); end
        checks++; if (wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", wdata); end
        tick();
        rdata = 32'hDEAD_BEEF;
        drive(5'd12, 32'h304, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1);
        checks++; if (alu_out !== 32'h301 || we_out !== 1'b0) begin errors++; $display("FAIL sb_done: got alu=%h we=%b exp 301/0", alu_out, we_out); end
        #1;
        checks++; if (req !== 1'b1 || addr !== 32'h304) begin errors++; $display("FAIL lw_req: got req=%b addr=%h exp 1/304", req, addr); end
        tick();
        drive(5'd13, 32'h308, 3'd6, 2'd0, 32'd0, 1'b0, 1'b1);
        checks++; if (load_out !== 32'hDEAD_BEEF || rd_out !== 5'd12 || we_out !== 1'b1) begin errors++; $display("FAIL lw_done: got data=%h rd=%0d we=%b exp deadbeef/12/1", load_out, rd_out, we_out); end
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL code6_req: got %b exp 0", req); end
        tick();
        bubble();
        checks++; if (rd_out !== 5'd13 || we_out !== 1'b1 || load_out !== 32'd0) begin errors++; $display("FAIL code6_wb: got rd=%0d we=%b data=%h exp 13/1/0", rd_out, we_out, load_out); end
        ready = 1'b0;
        $display("back to back: done");
    endtask

    task automatic test_reset_in_wait();
        ready = 1'b0; rdata = 32'h5555_5555;
        drive(5'd9, 32'h40, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1);
        #1;
        checks++; if (req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL rw_issue: got req=%b stall=%b exp 1/1", req, stall); end
        tick();
        bubble();
        #1;
        checks++; if (req !== 1'b1 || addr !== 32'h40) begin errors++; $display("FAIL rw_wait1: got req=%b addr=%h exp 1/40", req, addr); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rw_rst_force: got req=%b stall=%b exp 0/0", req, stall); end
        tick();
        rst = 1'b0;
        checks++; if (we_out !== 1'b0 || alu_out !== 32'd0 || rd_out !== 5'd0 || load_out !== 32'd0) begin errors++; $display("FAIL rw_outs: got we=%b alu=%h rd=%0d data=%h exp all 0", we_out, alu_out, rd_out, load_out); end
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rw_idle_req: got %b exp 0", req); end
        ready = 1'b1;
        tick();
        checks++; if (we_out !== 1'b0 || load_out !== 32'd0) begin errors++; $display("FAIL rw_no_wb: got we=%b data=%h exp 0/0", we_out, load_out); end
        ready = 1'b0;
        $display("reset in wait: done");
    endtask

    task automatic test_misalign();
        rdata = 32'h1122_3344;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        ready = 1'b0;
        drive(5'd4, 32'h41, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1);
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_req: got req=%b stall=%b exp 0/0", req, stall); end
        tick();
        bubble();
        checks++; if (mis_out !== 1'b1 || mis_addr !== 32'h41) begin errors++; $display("FAIL mis_flag: got %b addr=%h exp 1/41", mis_out, mis_addr); end
        checks++; if (we_out !== 1'b0 || alu_out !== 32'd0) begin errors++; $display("FAIL mis_bubble: got we=%b alu=%h exp 0/0", we_out, alu_out); end
        tick();
        checks++; if (mis_out !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b exp 0", mis_out); end
        $display("misalign trap: done");
`else
        ready = 1'b1;
        drive(5'd4, 32'h41, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1);
        #1;
        checks++; if (req !== 1'b1 || addr !== 32'h40 || stall !== 1'b0) begin errors++; $display("FAIL align_req: got req=%b addr=%h stall=%b exp 1/40/0", req, addr, stall); end
        tick();
        bubble();
        checks++; if (load_out !== 32'h1122_3344 || we_out !== 1'b1 || alu_out !== 32'h41) begin errors++; $display("FAIL align_done: got data=%h we=%b alu=%h exp 11223344/1/41", load_out, we_out, alu_out); end
        ready = 1'b0;
        $display("forced alignment: done");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_extract();
        test_store_wait();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
